ufk_result_writer: RTL and testbench
====================================

# ufk_result_writer

Downstream stage of the UKF sum datapath. Consumes 32-bit sum results one at a time over a valid/ready handshake, packs four consecutive results into one 128-bit word, and writes each packed word into the on-chip result RAM region (addresses 32–63). Shares the RAM port with the read-side controller through an external `mem_grant` signal. Raises `done` once a full frame of `NUM_WORDS` words has been written.

## Interface
Parameters:
- `BASE_ADDR`, 32: RAM word address of the first packed word.
- `NUM_WORDS`, 32: packed words per frame. Requires `BASE_ADDR + NUM_WORDS <= 64`; elaboration fails otherwise.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- `sum_data`  in  32  result lane from the sum stage.
- `sum_valid`  in  1  `sum_data` is valid.
- `sum_ready`  out  1  writer accepts `sum_data` this cycle.
- `mem_grant`  in  1  arbiter grants the RAM port to this block this cycle.
- `address`  out  6  RAM word address.
- `writedata`  out  128  packed word; lane k is at bits [32k+31:32k].
- `byteenable`  out  16  16'hFFFF when `write` is high, else 0.
- `write`  out  1  RAM write strobe.
- `chipselect`  out  1  equal to `write`.
- `clken`  out  1  RAM clock enable; 0 during reset, 1 otherwise.
- `busy`  out  1  frame in progress (RUN state).
- `done`  out  1  one-cycle pulse after the last word of the frame is written.

## Operation
- State machine: IDLE → RUN on `start`. RUN → DONE in the cycle the `NUM_WORDS`-th write occurs. DONE → IDLE unconditionally after one cycle.
- Counters:
  - `lane` (2 bit) selects the pack lane.
  - `acc_cnt` (7 bit) counts words packed.
  - `wr_cnt` (7 bit) counts words written.
  - All three clear on entering RUN.
- Pack register `pack[127:0]`; output buffer `obuf[127:0]` with flag `pending`.
- Accept condition: `sum_valid && sum_ready`. On acceptance:
  - Write `sum_data` into `pack` lane `lane`, then increment `lane` (wrapping 3 → 0).
  - When lane 3 is accepted, move the complete word (with this cycle's lane 3) into `obuf`, set `pending`, and increment `acc_cnt`.
- `sum_ready` = RUN && `acc_cnt < NUM_WORDS` && (`lane != 3` || !`pending` || write-this-cycle). Lanes 0–2 of the next word are accepted while a word is still waiting in `obuf`.
- `write` = `chipselect` = `pending && mem_grant` (combinational from registered state and `mem_grant`).
- During a write:
  - `address` = `BASE_ADDR + wr_cnt[5:0]` and `writedata` = `obuf`.
  - `pending` clears and `wr_cnt` increments at the end of the write cycle, unless a lane-3 acceptance refills `obuf` in the same cycle; in that case `pending` stays 1.
- While `write` is 0, `address` and `writedata` hold their last values (0 after reset).
- `sum_valid` in IDLE or DONE is ignored and nothing is accepted. `start` in RUN or DONE is ignored.
- Lane values are stored exactly as received; no arithmetic is performed. Addresses never wrap because of the parameter constraint.
- `rst` at any point, including mid-frame:
  - State returns to IDLE, all counters and `pending` are 0, and the partial word is discarded.
  - Reset values: `sum_ready`=0, `write`=0, `chipselect`=0, `byteenable`=0, `address`=0, `writedata`=0, `busy`=0, `done`=0, `clken`=0.

## Timing
- `busy` rises in the cycle after `start` is sampled in IDLE.
- Latency from lane-3 acceptance in cycle N to the earliest write is cycle N+1 (requires `mem_grant`=1 in N+1).
- Sustained throughput is one 32-bit lane per cycle (one word per 4 cycles) when `mem_grant` is held at 1.
- Worst-case backpressure: `sum_ready` drops only when `lane`=3 with `pending`=1 and no write occurs in that cycle.
- `done` is high in the cycle after the final write. `busy` is low in that same cycle. A new `start` is accepted one cycle after `done`.

## Test plan
- Basic frame: reset, `start`, then 128 lanes with value i (i=0..127), `sum_valid`=1 and `mem_grant`=1 throughout → 32 writes at addresses 32..63; word j = {4j+3, 4j+2, 4j+1, 4j}; `done` pulses once, 1 cycle after the write to address 63.
- Grant stall: hold `mem_grant`=0 for 10 cycles after the first word completes → three more lanes accepted, `sum_ready`=0 at lane 3, then the writes resume in order with no lost or duplicated data.
- Simultaneous refill: `mem_grant` rises in the same cycle lane 3 of word 1 is accepted → word 0 is written at address 32, `obuf` holds word 1, `pending` stays 1, and word 1 is written at address 33 in the next cycle.
- Mid-frame reset: assert `rst` after 9 lanes → all outputs return to their reset values; a new `start` frame writes from address 32 again, and lane 0 of word 0 is the first post-reset datum.
- Ignored inputs: `sum_valid`=1 in IDLE and a second `start` in RUN → `sum_ready`=0 in IDLE, no writes, and the frame count is unchanged (exactly 32 writes).
- Parameter variant: `BASE_ADDR`=40, `NUM_WORDS`=4 → 4 writes at addresses 40..43, then `done`, and `sum_ready`=0 after 16 lanes.

Source files
------------

// File: rtl/ufk_result_writer_if.sv
// ufk_result_writer_if
//   Groups the sum-stage stream and the result-RAM port of the result writer.
//   slave  : the writer side (consumes the sum stream, drives the RAM port)
//   master : the environment side (drives the sum stream and mem_grant)
//   Signals:
//     sum_data/sum_valid/sum_ready : 32-bit valid/ready result stream
//     mem_grant                    : arbiter grant of the shared RAM port
//     address/writedata/byteenable : RAM word address, 128-bit data, byte enables
//     write/chipselect             : RAM write strobe and chip select
interface ufk_result_writer_if;
  logic [31:0]  sum_data;
  logic         sum_valid;
  logic         sum_ready;
  logic         mem_grant;
  logic [5:0]   address;
  logic [127:0] writedata;
  logic [15:0]  byteenable;
  logic         write;
  logic         chipselect;

  modport slave (
    input  sum_data, sum_valid, mem_grant,
    output sum_ready, address, writedata, byteenable, write, chipselect
  );

  modport master (
    output sum_data, sum_valid, mem_grant,
    input  sum_ready, address, writedata, byteenable, write, chipselect
  );
endinterface

// File: rtl/ufk_result_writer.sv
// ufk_result_writer
//   Packs four consecutive 32-bit sum results into one 128-bit word and writes
//   each word to the result RAM region starting at BASE_ADDR. A frame is
//   NUM_WORDS words; done pulses one cycle after the last write.
//   Ports:
//     clock  : rising-edge clock
//     rst    : synchronous active-high reset
//     start  : frame start pulse, honoured only in IDLE
//     bus    : sum stream + RAM port (slave modport of ufk_result_writer_if)
//     busy   : frame in progress
//     done   : one-cycle end-of-frame pulse
//     clken  : RAM clock enable, low while rst is asserted
module ufk_result_writer #(
  parameter int unsigned BASE_ADDR = 32,
  parameter int unsigned NUM_WORDS = 32
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  ufk_result_writer_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 clken
);

  if (BASE_ADDR + NUM_WORDS > 64) begin : g_param_check
    $error("ufk_result_writer: BASE_ADDR + NUM_WORDS must not exceed 64");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [6:0] NUM_W7  = 7'(NUM_WORDS);
  localparam logic [6:0] LAST_W7 = 7'(NUM_WORDS - 1);
  localparam logic [5:0] BASE_A6 = 6'(BASE_ADDR);

  state_t       r_state;
  logic [1:0]   r_lane;
  logic [6:0]   r_acc_cnt;
  logic [6:0]   r_wr_cnt;
  logic [127:0] r_pack;
  logic [127:0] r_obuf;
  logic         r_pending;
  logic [5:0]   r_addr_hold;
  logic [127:0] r_wdata_hold;

  logic         w_write;
  logic         w_ready;
  logic         w_accept;
  logic         w_lane3;
  logic [5:0]   w_wr_addr;

  assign w_write   = r_pending & bus.mem_grant;
  assign w_lane3   = (r_lane == 2'd3);
  // Lane 3 may only be taken if obuf is free or is being drained this cycle.
  assign w_ready   = (r_state == S_RUN) && (r_acc_cnt < NUM_W7) &&
                     (!w_lane3 || !r_pending || w_write);
  assign w_accept  = bus.sum_valid & w_ready;
  assign w_wr_addr = BASE_A6 + r_wr_cnt[5:0];

  assign bus.sum_ready  = w_ready;
  assign bus.write      = w_write;
  assign bus.chipselect = w_write;
  assign bus.byteenable = w_write ? '1 : '0;
  // Address/data show the live word during a write and hold the last one otherwise.
  assign bus.address    = w_write ? w_wr_addr : r_addr_hold;
  assign bus.writedata  = w_write ? r_obuf : r_wdata_hold;

  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign clken = ~rst;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lane       <= '0;
      r_acc_cnt    <= '0;
      r_wr_cnt     <= '0;
      r_pack       <= '0;
      r_obuf       <= '0;
      r_pending    <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_lane    <= '0;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
            r_pending <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_pack[{r_lane, 5'd0} +: 32] <= bus.sum_data;
            r_lane <= r_lane + 2'd1;
            if (w_lane3) begin
              r_obuf    <= {bus.sum_data, r_pack[95:0]};
              r_acc_cnt <= r_acc_cnt + 7'd1;
            end
          end
          // A same-cycle refill wins over the drain, keeping pending set.
          if (w_accept && w_lane3) begin
            r_pending <= 1'b1;
          end else if (w_write) begin
            r_pending <= 1'b0;
          end
          if (w_write) begin
            r_wr_cnt     <= r_wr_cnt + 7'd1;
            r_addr_hold  <= w_wr_addr;
            r_wdata_hold <= r_obuf;
            if (r_wr_cnt == LAST_W7) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ufk_result_writer.sv
module tb_ufk_result_writer;

  typedef struct {
    logic [5:0]   addr;
    logic [127:0] data;
  } exp_t;

  logic clock;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic clken;
  logic start2;
  logic busy2;
  logic done2;
  logic clken2;

  ufk_result_writer_if bus1();
  ufk_result_writer_if bus2();

  ufk_result_writer dut (
    .clock (clock),
    .rst   (rst),
    .start (start),
    .bus   (bus1),
    .busy  (busy),
    .done  (done),
    .clken (clken)
  );

  ufk_result_writer #(
    .BASE_ADDR (40),
    .NUM_WORDS (4)
  ) dut2 (
    .clock (clock),
    .rst   (rst),
    .start (start2),
    .bus   (bus2),
    .busy  (busy2),
    .done  (done2),
    .clken (clken2)
  );

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  exp_t q1[$];
  exp_t q2[$];
  int unsigned wcyc[$];
  int unsigned wr_seen = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned last_wr_cyc = 0;
  int unsigned wr2_seen = 0;
  int unsigned done2_cnt = 0;
  int unsigned done2_cyc = 0;
  int unsigned last_wr2_cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [127:0] mkword(input int unsigned v0);
    logic [31:0] a, b, c, d;
    a = v0;
    b = v0 + 1;
    c = v0 + 2;
    d = v0 + 3;
    return {d, c, b, a};
  endfunction

  // Scoreboard monitor for the default instance.
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus1.write) begin
      wr_seen++;
      last_wr_cyc = cyc;
      wcyc.push_back(cyc);
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h", bus1.address, bus1.writedata);
      end else begin
        e = q1.pop_front();
        if ({bus1.address, bus1.writedata, bus1.byteenable, bus1.chipselect} !==
            {e.addr, e.data, 16'hFFFF, 1'b1}) begin
          failures++;
          $display("FAIL write_word got addr=%0d data=%h be=%h cs=%b want addr=%0d data=%h be=ffff cs=1",
                   bus1.address, bus1.writedata, bus1.byteenable, bus1.chipselect, e.addr, e.data);
        end
      end
    end
  end

  // Scoreboard monitor for the parameter-variant instance.
  always @(negedge clock) begin
    exp_t e;
    if (done2) begin
      done2_cnt++;
      done2_cyc = cyc;
    end
    if (bus2.write) begin
      wr2_seen++;
      last_wr2_cyc = cyc;
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write2 addr=%0d data=%h", bus2.address, bus2.writedata);
      end else begin
        e = q2.pop_front();
        if ({bus2.address, bus2.writedata} !== {e.addr, e.data}) begin
          failures++;
          $display("FAIL write_word2 got addr=%0d data=%h want addr=%0d data=%h",
                   bus2.address, bus2.writedata, e.addr, e.data);
        end
      end
    end
  end

  // gmode: 0 grant always, 1 grant from k>=14, 2 grant from k>=7.
  task automatic run_frame(input int unsigned n_lanes, input int unsigned base,
                           input int unsigned gmode, input bit restart,
                           output int unsigned stalls, output int unsigned fs);
    int unsigned idx = 0;
    int unsigned k = 0;
    bit acc;
    exp_t e;
    stalls = 0;
    wr_seen = 0;
    done_cnt = 0;
    wcyc.delete();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    fs = cyc;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise got %b want 1", busy);
    end
    while (idx < n_lanes && k < 2000) begin
      bus1.sum_valid = 1'b1;
      bus1.sum_data  = base + idx;
      bus1.mem_grant = (gmode == 0) || (gmode == 1 && k >= 14) || (gmode == 2 && k >= 7);
      start = restart && (k == 20);
      @(negedge clock);
      acc = bus1.sum_ready;
      if (!acc) stalls++;
      @(posedge clock); #1;
      if (acc) begin
        if (idx % 4 == 3) begin
          e.addr = 6'(32 + idx / 4);
          e.data = mkword(base + idx - 3);
          q1.push_back(e);
        end
        idx++;
      end
      k++;
    end
    bus1.sum_valid = 1'b0;
    bus1.mem_grant = 1'b1;
    start = 1'b0;
    checks++;
    if (idx != n_lanes) begin
      failures++;
      $display("FAIL lane_budget got %0d lanes want %0d", idx, n_lanes);
    end
  endtask

  task automatic wait_done_and_check(input string nm, input int unsigned want_writes);
    int unsigned n = 0;
    bit seen = 0;
    while (!seen && n < 300) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL %s_busy_at_done got %b want 0", nm, busy);
        end
      end
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout got no done want done", nm);
    end
    checks++;
    if (wr_seen != want_writes || done_cnt != 1 || q1.size() != 0) begin
      failures++;
      $display("FAIL %s_counts got writes=%0d dones=%0d left=%0d want writes=%0d dones=1 left=0",
               nm, wr_seen, done_cnt, q1.size(), want_writes);
    end
    checks++;
    if (done_cyc != last_wr_cyc + 1) begin
      failures++;
      $display("FAIL %s_done_timing got cyc=%0d want cyc=%0d", nm, done_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    @(negedge clock);
    checks++;
    if ({bus1.sum_ready, bus1.write, bus1.chipselect, bus1.byteenable, bus1.address,
         bus1.writedata, busy, done, clken} !== 156'd0) begin
      failures++;
      $display("FAIL %s_outputs got rdy=%b wr=%b cs=%b be=%h a=%0d wd=%h busy=%b done=%b clken=%b want all 0",
               nm, bus1.sum_ready, bus1.write, bus1.chipselect, bus1.byteenable, bus1.address,
               bus1.writedata, busy, done, clken);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clock);
    check_reset_outputs("reset");
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    checks++;
    if (clken !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got clken=%b busy=%b want clken=1 busy=0", clken, busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    int unsigned st, fs;
    run_frame(128, 0, 0, 1'b0, st, fs);
    wait_done_and_check("basic", 32);
    checks++;
    if (st != 0) begin
      failures++;
      $display("FAIL basic_stalls got %0d want 0", st);
    end
    @(negedge clock);
    checks++;
    if (bus1.address !== 6'd63 || bus1.writedata !== mkword(124) || bus1.sum_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold got a=%0d wd=%h rdy=%b want a=63 wd=%h rdy=0",
               bus1.address, bus1.writedata, bus1.sum_ready, mkword(124));
    end
    @(posedge clock); #1;
  endtask

  task automatic test_grant_stall();
    int unsigned st, fs;
    run_frame(128, 1000, 1, 1'b0, st, fs);
    wait_done_and_check("stall", 32);
    checks++;
    if (st != 7) begin
      failures++;
      $display("FAIL stall_cycles got %0d want 7", st);
    end
    checks++;
    if (wcyc.size() == 0 || wcyc[0] != fs + 14) begin
      failures++;
      $display("FAIL stall_first_write got cyc=%0d want cyc=%0d",
               (wcyc.size() == 0) ? 0 : wcyc[0], fs + 14);
    end
  endtask

  task automatic test_refill();
    int unsigned st, fs;
    run_frame(128, 2000, 2, 1'b0, st, fs);
    wait_done_and_check("refill", 32);
    checks++;
    if (st != 0 || wcyc.size() < 2 || wcyc[0] != fs + 7 || wcyc[1] != fs + 8) begin
      failures++;
      $display("FAIL refill_timing got stalls=%0d w0=%0d w1=%0d want stalls=0 w0=%0d w1=%0d",
               st, (wcyc.size() > 0) ? wcyc[0] : 0, (wcyc.size() > 1) ? wcyc[1] : 0,
               fs + 7, fs + 8);
    end
  endtask

  task automatic test_mid_reset();
    int unsigned st, fs;
    run_frame(9, 3000, 0, 1'b0, st, fs);
    checks++;
    if (wr_seen != 2 || q1.size() != 0) begin
      failures++;
      $display("FAIL midrst_pre got writes=%0d left=%0d want writes=2 left=0", wr_seen, q1.size());
    end
    rst = 1'b1;
    @(posedge clock); #1;
    check_reset_outputs("midrst");
    @(posedge clock); #1;
    rst = 1'b0;
    run_frame(128, 5000, 0, 1'b0, st, fs);
    wait_done_and_check("midrst_frame", 32);
  endtask

  task automatic test_ignored();
    int unsigned st, fs;
    bus1.sum_valid = 1'b1;
    bus1.sum_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (bus1.sum_ready !== 1'b0 || bus1.write !== 1'b0) begin
        failures++;
        $display("FAIL idle_ignore got rdy=%b wr=%b want 0 0", bus1.sum_ready, bus1.write);
      end
      @(posedge clock); #1;
    end
    bus1.sum_valid = 1'b0;
    run_frame(128, 9000, 0, 1'b1, st, fs);
    wait_done_and_check("restart_ignore", 32);
  endtask

  task automatic test_variant();
    int unsigned idx = 0;
    bit acc;
    exp_t e;
    wr2_seen = 0;
    done2_cnt = 0;
    start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      bus2.sum_valid = 1'b1;
      bus2.sum_data  = 7000 + idx;
      bus2.mem_grant = 1'b1;
      @(negedge clock);
      acc = bus2.sum_ready;
      if (k == 16) begin
        checks++;
        if (acc !== 1'b0 || idx != 16) begin
          failures++;
          $display("FAIL variant_ready_drop got rdy=%b lanes=%0d want rdy=0 lanes=16", acc, idx);
        end
      end
      @(posedge clock); #1;
      if (acc) begin
        if (idx % 4 == 3) begin
          e.addr = 6'(40 + idx / 4);
          e.data = mkword(7000 + idx - 3);
          q2.push_back(e);
        end
        idx++;
      end
    end
    bus2.sum_valid = 1'b0;
    checks++;
    if (wr2_seen != 4 || done2_cnt != 1 || q2.size() != 0 || idx != 16) begin
      failures++;
      $display("FAIL variant_counts got writes=%0d dones=%0d left=%0d lanes=%0d want 4 1 0 16",
               wr2_seen, done2_cnt, q2.size(), idx);
    end
    checks++;
    if (done2_cyc != last_wr2_cyc + 1) begin
      failures++;
      $display("FAIL variant_done_timing got cyc=%0d want cyc=%0d", done2_cyc, last_wr2_cyc + 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    bus1.sum_valid = 1'b0;
    bus1.sum_data  = '0;
    bus1.mem_grant = 1'b0;
    bus2.sum_valid = 1'b0;
    bus2.sum_data  = '0;
    bus2.mem_grant = 1'b0;
    test_reset();
    test_basic();
    test_grant_stall();
    test_refill();
    test_mid_reset();
    test_ignored();
    test_variant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
